// File: rtl/local_memory_arbiter.sv
// Round-robin arbiter sharing one local-memory port between requesters A and B.
// The winner's request is latched for the whole access; hung accesses are aborted by timeout.
`timescale 1ns/1ps

module local_memory_arbiter #(
    parameter int ADDRESS_WIDTH  = 24,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDRESS_WIDTH-1:0] reqAAddress,
    input  logic [3:0]               reqAByteSelect,
    input  logic                     reqAEnable,
    input  logic                     reqAWriteEnable,
    input  logic [31:0]              reqADataWrite,
    output logic [31:0]              reqADataRead,
    output logic                     reqABusy,
    output logic                     reqAError,
    input  logic [ADDRESS_WIDTH-1:0] reqBAddress,
    input  logic [3:0]               reqBByteSelect,
    input  logic                     reqBEnable,
    input  logic                     reqBWriteEnable,
    input  logic [31:0]              reqBDataWrite,
    output logic [31:0]              reqBDataRead,
    output logic                     reqBBusy,
    output logic                     reqBError,
    output logic [ADDRESS_WIDTH-1:0] memAddress,
    output logic [3:0]               memByteSelect,
    output logic                     memEnable,
    output logic                     memWriteEnable,
    output logic [31:0]              memDataWrite,
    input  logic [31:0]              memDataRead,
    input  logic                     memBusy
);

    typedef enum logic {IDLE, ACCESS} state_t;

    localparam logic       OWNER_A      = 1'b0;
    localparam logic       OWNER_B      = 1'b1;
    localparam logic       TIMEOUT_ON   = (TIMEOUT_CYCLES != 0);
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t                   state;
    logic                     owner;
    logic                     last_grant;
    logic [7:0]               timeout_count;
    logic [ADDRESS_WIDTH-1:0] lat_address;
    logic [3:0]               lat_byte_select;
    logic                     lat_write_enable;
    logic [31:0]              lat_data_write;

    logic grant_a;
    logic grant_b;
    logic winner;
    logic timed_out;
    logic access_done;
    logic report_a;
    logic report_b;

    // A tie goes to whoever did not win last time.
    assign grant_a = reqAEnable && (!reqBEnable || (last_grant == OWNER_B));
    assign grant_b = reqBEnable && !grant_a;
    assign winner  = grant_a ? OWNER_A : OWNER_B;

    assign timed_out   = TIMEOUT_ON && memBusy && (timeout_count == TIMEOUT_LAST);
    assign access_done = (state == ACCESS) && (!memBusy || timed_out);

    // A completion is only reported to an owner that is still asking for it.
    assign report_a = rst && access_done && (owner == OWNER_A) && reqAEnable;
    assign report_b = rst && access_done && (owner == OWNER_B) && reqBEnable;

    assign reqABusy     = reqAEnable && !report_a;
    assign reqBBusy     = reqBEnable && !report_b;
    assign reqAError    = report_a && timed_out;
    assign reqBError    = report_b && timed_out;
    assign reqADataRead = (report_a && !timed_out) ? memDataRead : 32'hFFFF_FFFF;
    assign reqBDataRead = (report_b && !timed_out) ? memDataRead : 32'hFFFF_FFFF;

    always_comb begin
        memAddress     = '0;
        memByteSelect  = '0;
        memEnable      = 1'b0;
        memWriteEnable = 1'b0;
        memDataWrite   = '0;
        if (rst) begin
            if (state == ACCESS) begin
                memAddress     = lat_address;
                memByteSelect  = lat_byte_select;
                memEnable      = 1'b1;
                memWriteEnable = lat_write_enable;
                memDataWrite   = lat_data_write;
            end else if (grant_a) begin
                memAddress     = reqAAddress;
                memByteSelect  = reqAByteSelect;
                memEnable      = 1'b1;
                memWriteEnable = reqAWriteEnable;
                memDataWrite   = reqADataWrite;
            end else if (grant_b) begin
                memAddress     = reqBAddress;
                memByteSelect  = reqBByteSelect;
                memEnable      = 1'b1;
                memWriteEnable = reqBWriteEnable;
                memDataWrite   = reqBDataWrite;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state            <= IDLE;
            owner            <= OWNER_A;
            last_grant       <= OWNER_B;
            timeout_count    <= '0;
            lat_address      <= '0;
            lat_byte_select  <= '0;
            lat_write_enable <= 1'b0;
            lat_data_write   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_a || grant_b) begin
                        state            <= ACCESS;
                        owner            <= winner;
                        last_grant       <= winner;
                        timeout_count    <= '0;
                        lat_address      <= grant_a ? reqAAddress     : reqBAddress;
                        lat_byte_select  <= grant_a ? reqAByteSelect  : reqBByteSelect;
                        lat_write_enable <= grant_a ? reqAWriteEnable : reqBWriteEnable;
                        lat_data_write   <= grant_a ? reqADataWrite   : reqBDataWrite;
                    end
                end
                ACCESS: begin
                    // Not done here implies memBusy is high, so this counts wait states.
                    if (access_done) begin
                        state <= IDLE;
                    end else begin
                        timeout_count <= timeout_count + 8'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_local_memory_arbiter.sv
// Directed and randomized bench for local_memory_arbiter, checked against a
// transaction-level model of the arbitration, wait-state and timeout rules.
`timescale 1ns/1ps

module tb_local_memory_arbiter;

    localparam int TO = 4;

    logic        clk;
    logic        rst;
    logic        a_en, a_we, b_en, b_we;
    logic [23:0] a_addr, b_addr;
    logic [3:0]  a_bs, b_bs;
    logic [31:0] a_wd, b_wd;
    logic [31:0] a_rd, b_rd;
    logic        a_busy, b_busy, a_err, b_err;
    logic [23:0] mem_address;
    logic [3:0]  mem_byte_select;
    logic        mem_enable, mem_write_enable;
    logic [31:0] mem_data_write;
    logic [31:0] mem_rd;
    logic        mem_busy;

    int checks = 0;
    int errors = 0;

    // Model: one access in flight at most, plus who gets the next tie.
    bit          m_active;
    bit          m_owner;
    bit          m_pref;
    int          m_waited;
    logic [23:0] m_addr;
    logic [3:0]  m_bs;
    logic        m_we;
    logic [31:0] m_wd;
    bit          ev_issue, ev_finish, ev_winner;
    bit          done_a, done_b;
    bit          random_mode;

    local_memory_arbiter #(.ADDRESS_WIDTH(24), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .reqAAddress(a_addr), .reqAByteSelect(a_bs), .reqAEnable(a_en),
        .reqAWriteEnable(a_we), .reqADataWrite(a_wd), .reqADataRead(a_rd),
        .reqABusy(a_busy), .reqAError(a_err),
        .reqBAddress(b_addr), .reqBByteSelect(b_bs), .reqBEnable(b_en),
        .reqBWriteEnable(b_we), .reqBDataWrite(b_wd), .reqBDataRead(b_rd),
        .reqBBusy(b_busy), .reqBError(b_err),
        .memAddress(mem_address), .memByteSelect(mem_byte_select),
        .memEnable(mem_enable), .memWriteEnable(mem_write_enable),
        .memDataWrite(mem_data_write), .memDataRead(mem_rd), .memBusy(mem_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=no_finish expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic setA(input logic en, input logic we, input logic [23:0] addr,
                        input logic [3:0] bs, input logic [31:0] wd);
        a_en = en; a_we = we; a_addr = addr; a_bs = bs; a_wd = wd;
    endtask

    task automatic setB(input logic en, input logic we, input logic [23:0] addr,
                        input logic [3:0] bs, input logic [31:0] wd);
        b_en = en; b_we = we; b_addr = addr; b_bs = bs; b_wd = wd;
    endtask

    task automatic applyStimulus(input logic r, input logic mb, input logic [31:0] md);
        rst = r; mem_busy = mb; mem_rd = md;
        #4;
    endtask

    task automatic checkOutput();
        logic [23:0] e_addr;
        logic [3:0]  e_bs;
        logic        e_en, e_we, e_busy_a, e_busy_b, e_err_a, e_err_b, stuck;
        logic [31:0] e_wd, e_rd_a, e_rd_b;
        e_addr = '0; e_bs = '0; e_en = 0; e_we = 0; e_wd = '0;
        e_busy_a = a_en; e_busy_b = b_en; e_err_a = 0; e_err_b = 0;
        e_rd_a = 32'hFFFF_FFFF; e_rd_b = 32'hFFFF_FFFF;
        ev_issue = 0; ev_finish = 0; ev_winner = 0;
        if (rst) begin
            if (!m_active) begin
                if (a_en || b_en) begin
                    ev_winner = (a_en && b_en) ? m_pref : !a_en;
                    ev_issue  = 1;
                    e_en      = 1;
                    if (!ev_winner) begin
                        e_addr = a_addr; e_bs = a_bs; e_we = a_we; e_wd = a_wd;
                    end else begin
                        e_addr = b_addr; e_bs = b_bs; e_we = b_we; e_wd = b_wd;
                    end
                end
            end else begin
                e_en = 1; e_addr = m_addr; e_bs = m_bs; e_we = m_we; e_wd = m_wd;
                stuck = (TO != 0) && mem_busy && (m_waited + 1 == TO);
                if (!mem_busy || stuck) begin
                    ev_finish = 1;
                    if (!m_owner && a_en) begin
                        e_busy_a = 0;
                        if (stuck) e_err_a = 1; else e_rd_a = mem_rd;
                    end
                    if (m_owner && b_en) begin
                        e_busy_b = 0;
                        if (stuck) e_err_b = 1; else e_rd_b = mem_rd;
                    end
                end
            end
        end
        done_a = rst && a_en && !e_busy_a;
        done_b = rst && b_en && !e_busy_b;
        checkValue("memAddress",     32'(mem_address),      32'(e_addr));
        checkValue("memByteSelect",  32'(mem_byte_select),  32'(e_bs));
        checkValue("memEnable",      32'(mem_enable),       32'(e_en));
        checkValue("memWriteEnable", 32'(mem_write_enable), 32'(e_we));
        checkValue("memDataWrite",   mem_data_write,        e_wd);
        checkValue("reqABusy",       32'(a_busy),           32'(e_busy_a));
        checkValue("reqBBusy",       32'(b_busy),           32'(e_busy_b));
        checkValue("reqAError",      32'(a_err),            32'(e_err_a));
        checkValue("reqBError",      32'(b_err),            32'(e_err_b));
        checkValue("reqADataRead",   a_rd,                  e_rd_a);
        checkValue("reqBDataRead",   b_rd,                  e_rd_b);
    endtask

    task automatic tick();
        if (!rst) begin
            m_active = 0; m_pref = 0; m_waited = 0;
        end else if (ev_issue) begin
            m_active = 1; m_owner = ev_winner; m_pref = !ev_winner; m_waited = 0;
            m_addr = ev_winner ? b_addr : a_addr;
            m_bs   = ev_winner ? b_bs   : a_bs;
            m_we   = ev_winner ? b_we   : a_we;
            m_wd   = ev_winner ? b_wd   : a_wd;
        end else if (m_active) begin
            if (ev_finish) m_active = 0;
            else m_waited++;
        end
        @(posedge clk);
        #1;
        if (done_a) a_en = 0;
        if (done_b) b_en = 0;
        if (random_mode) begin
            if (!a_en && $urandom_range(0, 2) == 0)
                setA(1'b1, 1'($urandom_range(0, 1)), 24'($urandom), 4'($urandom), $urandom);
            if (!b_en && $urandom_range(0, 2) == 0)
                setB(1'b1, 1'($urandom_range(0, 1)), 24'($urandom), 4'($urandom), $urandom);
        end
    endtask

    task automatic cycle(input logic r, input logic mb, input logic [31:0] md);
        applyStimulus(r, mb, md);
        checkOutput();
        tick();
    endtask

    task automatic drain();
        int n = 0;
        while ((a_en || b_en || m_active) && n < 30) begin
            cycle(1'b1, 1'b0, $urandom);
            n++;
        end
        checkValue("drain_bound", {29'b0, a_en, b_en, m_active}, 32'h0);
    endtask

    initial begin
        random_mode = 0;
        m_active = 0; m_owner = 0; m_pref = 0; m_waited = 0;
        m_addr = '0; m_bs = '0; m_we = 0; m_wd = '0;
        setA(0, 0, 0, 0, 0);
        setB(0, 0, 0, 0, 0);
        rst = 0; mem_busy = 0; mem_rd = '0;
        @(posedge clk);
        #1;
        cycle(1'b0, 1'b0, 32'h0);

        // Single read by A
        setA(1, 0, 24'h000100, 4'hF, 32'h0);
        applyStimulus(1, 0, 32'h0); checkOutput();
        checkValue("t1_addr_c0", 32'(mem_address), 32'h000100);
        checkValue("t1_busy_c0", 32'(a_busy), 32'h1);
        tick();
        applyStimulus(1, 0, 32'h12345678); checkOutput();
        checkValue("t1_addr_c1", 32'(mem_address), 32'h000100);
        checkValue("t1_busy_c1", 32'(a_busy), 32'h0);
        checkValue("t1_rd_c1", a_rd, 32'h12345678);
        tick();
        cycle(1, 0, 32'h0);

        // Tie after reset: A first, then B, then A wins the next tie
        cycle(0, 0, 32'h0);
        setA(1, 0, 24'h000200, 4'hF, 32'h0);
        setB(1, 1, 24'h000300, 4'hF, 32'hCAFE0001);
        applyStimulus(1, 0, 32'h0); checkOutput();
        checkValue("t2_tie_a", 32'(mem_address), 32'h000200);
        tick();
        applyStimulus(1, 0, 32'hA5A5A5A5); checkOutput();
        checkValue("t2_a_done", 32'(a_busy), 32'h0);
        checkValue("t2_b_wait", 32'(b_busy), 32'h1);
        tick();
        applyStimulus(1, 0, 32'h0); checkOutput();
        checkValue("t2_b_issue", 32'(mem_address), 32'h000300);
        checkValue("t2_b_we", 32'(mem_write_enable), 32'h1);
        tick();
        applyStimulus(1, 0, 32'h0); checkOutput();
        checkValue("t2_b_done", 32'(b_busy), 32'h0);
        tick();
        setA(1, 0, 24'h000204, 4'hF, 32'h0);
        setB(1, 0, 24'h000304, 4'hF, 32'h0);
        applyStimulus(1, 0, 32'h0); checkOutput();
        checkValue("t2_tie2_a", 32'(mem_address), 32'h000204);
        tick();
        drain();

        // B write with three wait states while A waits
        setB(1, 1, 24'h000400, 4'b0011, 32'hDEADBEEF);
        cycle(1, 0, 32'h0);
        setA(1, 0, 24'h000500, 4'hF, 32'h0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 1, $urandom); checkOutput();
            checkValue("t3_wd_hold", mem_data_write, 32'hDEADBEEF);
            checkValue("t3_bs_hold", 32'(mem_byte_select), 32'h3);
            checkValue("t3_a_waits", 32'(a_busy), 32'h1);
            checkValue("t3_b_busy", 32'(b_busy), 32'h1);
            tick();
        end
        applyStimulus(1, 0, 32'h0); checkOutput();
        checkValue("t3_b_done", 32'(b_busy), 32'h0);
        checkValue("t3_addr_last", 32'(mem_address), 32'h000400);
        tick();
        drain();

        // Timeout on A with B pending
        setA(1, 0, 24'h000600, 4'hF, 32'h0);
        cycle(1, 0, 32'h0);
        setB(1, 0, 24'h000700, 4'hF, 32'h0);
        for (int i = 0; i < TO - 1; i++) begin
            applyStimulus(1, 1, $urandom); checkOutput();
            checkValue("t4_no_err", 32'(a_err), 32'h0);
            tick();
        end
        applyStimulus(1, 1, 32'h55AA55AA); checkOutput();
        checkValue("t4_err", 32'(a_err), 32'h1);
        checkValue("t4_busy", 32'(a_busy), 32'h0);
        checkValue("t4_rd", a_rd, 32'hFFFFFFFF);
        tick();
        applyStimulus(1, 0, 32'h0); checkOutput();
        checkValue("t4_b_issue", 32'(mem_address), 32'h000700);
        checkValue("t4_err_gone", 32'(a_err), 32'h0);
        tick();
        drain();

        // Reset during an access
        setA(1, 0, 24'h000800, 4'hF, 32'h0);
        cycle(1, 0, 32'h0);
        cycle(1, 1, 32'h0);
        setB(1, 0, 24'h000900, 4'hF, 32'h0);
        applyStimulus(0, 1, 32'h0); checkOutput();
        checkValue("t5_rst_en", 32'(mem_enable), 32'h0);
        checkValue("t5_rst_busy", 32'(a_busy), 32'h1);
        tick();
        a_en = 0; b_en = 0;
        applyStimulus(1, 1, 32'h0); checkOutput();
        checkValue("t5_after_en", 32'(mem_enable), 32'h0);
        checkValue("t5_after_err", 32'(a_err), 32'h0);
        tick();
        setA(1, 0, 24'h000804, 4'hF, 32'h0);
        setB(1, 0, 24'h000904, 4'hF, 32'h0);
        applyStimulus(1, 0, 32'h0); checkOutput();
        checkValue("t5_tie_a", 32'(mem_address), 32'h000804);
        tick();
        drain();

        // Owner drops enable during wait states
        setA(1, 0, 24'h000A00, 4'hF, 32'h0);
        cycle(1, 0, 32'h0);
        setB(1, 0, 24'h000B00, 4'hF, 32'h0);
        cycle(1, 1, 32'h0);
        a_en = 0;
        applyStimulus(1, 1, 32'h0); checkOutput();
        checkValue("t6_addr_hold", 32'(mem_address), 32'h000A00);
        checkValue("t6_en_hold", 32'(mem_enable), 32'h1);
        tick();
        applyStimulus(1, 0, 32'h87654321); checkOutput();
        checkValue("t6_addr_done", 32'(mem_address), 32'h000A00);
        checkValue("t6_a_busy", 32'(a_busy), 32'h0);
        checkValue("t6_a_err", 32'(a_err), 32'h0);
        checkValue("t6_a_rd", a_rd, 32'hFFFFFFFF);
        tick();
        applyStimulus(1, 0, 32'h0); checkOutput();
        checkValue("t6_b_issue", 32'(mem_address), 32'h000B00);
        tick();
        drain();

        // Randomized traffic with wait states, timeouts and occasional resets
        random_mode = 1;
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 59) != 0), 1'($urandom_range(0, 9) < 4), $urandom);
        end
        random_mode = 0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
